// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting a shared single-port memory to one of two requesters,
// with a hold limit that revokes a tenure only when the other side is waiting.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_HOLD   = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic                  we0,
  input  logic                  we1,
  output logic                  grant0,
  output logic                  grant1,
  output logic                  preempt0,
  output logic                  preempt1,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we
);

  // state | meaning
  // IDLE  | no owner; every ownership change passes through here
  // OWN0  | requester 0 owns the memory
  // OWN1  | requester 1 owns the memory
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state;
  logic       prio;
  logic [7:0] hold_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      prio     <= 1'b0;
      hold_cnt <= 8'd0;
      preempt0 <= 1'b0;
      preempt1 <= 1'b0;
    end else begin
      preempt0 <= 1'b0;
      preempt1 <= 1'b0;
      case (state)
        IDLE: begin
          hold_cnt <= 8'd0;
          if (req0 && (!req1 || !prio)) state <= OWN0;
          else if (req1)                state <= OWN1;
        end
        OWN0: begin
          // release takes precedence over timeout, so no pulse on a coincident drop
          if (!req0) begin
            state    <= IDLE;
            prio     <= 1'b1;
            hold_cnt <= 8'd0;
          end else if (hold_cnt == HOLD_LAST && req1) begin
            state    <= IDLE;
            prio     <= 1'b1;
            hold_cnt <= 8'd0;
            preempt0 <= 1'b1;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        OWN1: begin
          if (!req1) begin
            state    <= IDLE;
            prio     <= 1'b0;
            hold_cnt <= 8'd0;
          end else if (hold_cnt == HOLD_LAST && req0) begin
            state    <= IDLE;
            prio     <= 1'b0;
            hold_cnt <= 8'd0;
            preempt1 <= 1'b1;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          state    <= IDLE;
          hold_cnt <= 8'd0;
        end
      endcase
    end
  end

  assign grant0 = (state == OWN0);
  assign grant1 = (state == OWN1);

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (state == OWN0) begin
      mem_addr  = addr0;
      mem_wdata = wdata0;
      mem_we    = we0;
    end else if (state == OWN1) begin
      mem_addr  = addr1;
      mem_wdata = wdata1;
      mem_we    = we1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with MAX_HOLD=4: grant/release latency, round-robin,
// timeout preemption, saturation without contention, datapath isolation and reset.
module tb_mem_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [6:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       we0 = 1'b0, we1 = 1'b0;
  logic       grant0, grant1, preempt0, preempt1;
  logic [6:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .MAX_HOLD(4)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .we0(we0), .we1(we1),
    .grant0(grant0), .grant1(grant1),
    .preempt0(preempt0), .preempt1(preempt1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; addr0 = 7'h33;
    tick(); tick();
    n_cmp++; if ({grant0, grant1} !== 2'b00) begin n_err++; $display("FAIL reset_grants: got %b want 00", {grant0, grant1}); end
    n_cmp++; if ({preempt0, preempt1} !== 2'b00) begin n_err++; $display("FAIL reset_preempt: got %b want 00", {preempt0, preempt1}); end
    n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== 16'h0000) begin n_err++; $display("FAIL reset_mem: got we=%b addr=%h wdata=%h want 0/00/00", mem_we, mem_addr, mem_wdata); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    req0 = 1'b1; addr0 = 7'h05; wdata0 = 8'h2A; we0 = 1'b1;
    tick();
    n_cmp++; if ({grant0, grant1} !== 2'b10) begin n_err++; $display("FAIL single_grant: got %b want 10", {grant0, grant1}); end
    n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 7'h05, 8'h2A}) begin n_err++; $display("FAIL single_mem: got we=%b addr=%h wdata=%h want 1/05/2a", mem_we, mem_addr, mem_wdata); end
    req0 = 1'b0;
    tick();
    n_cmp++; if ({grant0, mem_we, mem_addr} !== 9'd0) begin n_err++; $display("FAIL single_release: got grant0=%b we=%b addr=%h want 0/0/00", grant0, mem_we, mem_addr); end
    we0 = 1'b0;
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int r = 0; r < 4; r++) begin
      req0 = 1'b1; req1 = 1'b1;
      for (int c = 0; c < 3; c++) begin
        tick();
        n_cmp++; if ({grant0, grant1, preempt0} !== 3'b100) begin n_err++; $display("FAIL rr_own0 round %0d cycle %0d: got g0g1p0=%b want 100", r, c, {grant0, grant1, preempt0}); end
      end
      req0 = 1'b0;
      tick();
      n_cmp++; if ({grant0, grant1} !== 2'b00) begin n_err++; $display("FAIL rr_idle round %0d: got %b want 00", r, {grant0, grant1}); end
      tick();
      n_cmp++; if ({grant0, grant1} !== 2'b01) begin n_err++; $display("FAIL rr_own1 round %0d: got %b want 01", r, {grant0, grant1}); end
      req1 = 1'b0;
      tick();
      n_cmp++; if ({grant0, grant1} !== 2'b00) begin n_err++; $display("FAIL rr_rel1 round %0d: got %b want 00", r, {grant0, grant1}); end
    end
    // a solo tenure of 0 hands the tie to requester 1
    req0 = 1'b1; tick(); req0 = 1'b0; tick();
    req0 = 1'b1; req1 = 1'b1;
    tick();
    n_cmp++; if ({grant0, grant1} !== 2'b01) begin n_err++; $display("FAIL rr_prio1_tie: got %b want 01", {grant0, grant1}); end
    req0 = 1'b0; req1 = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    req0 = 1'b1;
    tick();
    tick();
    req1 = 1'b1;
    for (int c = 2; c < 4; c++) begin
      tick();
      n_cmp++; if ({grant0, grant1, preempt0} !== 3'b100) begin n_err++; $display("FAIL to_hold cycle %0d: got g0g1p0=%b want 100", c + 1, {grant0, grant1, preempt0}); end
    end
    tick();
    n_cmp++; if ({grant0, grant1, preempt0, preempt1} !== 4'b0010) begin n_err++; $display("FAIL to_preempt: got g0g1p0p1=%b want 0010", {grant0, grant1, preempt0, preempt1}); end
    tick();
    n_cmp++; if ({grant0, grant1, preempt0} !== 3'b010) begin n_err++; $display("FAIL to_grant1: got g0g1p0=%b want 010", {grant0, grant1, preempt0}); end
    tick();
    req1 = 1'b0;
    tick();
    n_cmp++; if ({grant0, grant1, preempt1} !== 3'b000) begin n_err++; $display("FAIL to_rel1: got g0g1p1=%b want 000", {grant0, grant1, preempt1}); end
    tick();
    n_cmp++; if ({grant0, grant1} !== 2'b10) begin n_err++; $display("FAIL to_regrant0: got %b want 10", {grant0, grant1}); end
    req0 = 1'b0;
    tick();
  endtask

  task automatic test_no_contention();
    int bad;
    do_reset();
    bad = 0;
    req0 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (grant0 !== 1'b1 || preempt0 !== 1'b0 || grant1 !== 1'b0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL nc_hold40: got %0d bad cycles want 0", bad); end
    addr0 = 7'h03; wdata0 = 8'h11; we0 = 1'b0;
    addr1 = 7'h10; wdata1 = 8'hFF; we1 = 1'b1;
    tick();
    n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b0, 7'h03, 8'h11}) begin n_err++; $display("FAIL nc_isolate: got we=%b addr=%h wdata=%h want 0/03/11", mem_we, mem_addr, mem_wdata); end
    req0 = 1'b0;
    tick();
    n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== 16'h0000) begin n_err++; $display("FAIL nc_idle_mem: got we=%b addr=%h wdata=%h want 0/00/00", mem_we, mem_addr, mem_wdata); end
    we1 = 1'b0;
  endtask

  task automatic test_release_on_timeout();
    do_reset();
    req0 = 1'b1;
    tick();
    req1 = 1'b1;
    tick(); tick(); tick();
    req0 = 1'b0;
    tick();
    n_cmp++; if ({grant0, grant1, preempt0} !== 3'b000) begin n_err++; $display("FAIL rt_no_preempt: got g0g1p0=%b want 000", {grant0, grant1, preempt0}); end
    tick();
    n_cmp++; if ({grant1, preempt0} !== 2'b10) begin n_err++; $display("FAIL rt_grant1: got g1p0=%b want 10", {grant1, preempt0}); end
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_tenure();
    do_reset();
    req0 = 1'b1; tick(); req0 = 1'b0; tick();
    req1 = 1'b1;
    tick();
    req0 = 1'b1; addr1 = 7'h10; wdata1 = 8'h55; we1 = 1'b1;
    tick();
    n_cmp++; if ({grant1, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 7'h10, 8'h55}) begin n_err++; $display("FAIL rm_own1: got g1=%b we=%b addr=%h wdata=%h want 1/1/10/55", grant1, mem_we, mem_addr, mem_wdata); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if ({grant0, grant1, preempt0, preempt1, mem_we, mem_addr, mem_wdata} !== 20'd0) begin n_err++; $display("FAIL rm_cleared: got g=%b%b p=%b%b we=%b addr=%h wdata=%h want all 0", grant0, grant1, preempt0, preempt1, mem_we, mem_addr, mem_wdata); end
    tick();
    n_cmp++; if ({grant0, grant1} !== 2'b10) begin n_err++; $display("FAIL rm_prio_reset: got %b want 10", {grant0, grant1}); end
    req0 = 1'b0; req1 = 1'b0; we1 = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_no_contention();
    test_release_on_timeout();
    test_reset_mid_tenure();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
